// File: rtl/io_pin_arbiter.sv
// Round-robin arbiter sharing one SB_IO pin bank between four requesters.
// Each ownership is bounded to MAX_HOLD cycles and ends with a one-cycle
// turnaround, so the bank is never handed directly from one owner to the next.
module io_pin_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [3:0]         req,
    input  logic [3:0]         oe_req,
    input  logic [4*WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0]   pin_din,
    output logic [WIDTH-1:0]   pin_dout,
    output logic               pin_oe,
    output logic [3:0]         gnt,
    output logic [WIDTH-1:0]   rdata,
    output logic               rvalid,
    output logic               timeout,
    output logic               busy
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StGrant = 2'd1;
    localparam logic [1:0] StTurn  = 2'd2;

    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       last_owner_q, last_owner_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic             pin_oe_q, pin_oe_d;
    logic [WIDTH-1:0] pin_dout_q, pin_dout_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;

    logic [1:0]       winner;
    logic             found;
    logic [1:0]       cand;
    logic [WIDTH-1:0] wsel;
    logic             owner_req;
    logic             owner_oe;

    // Round-robin pick: first requester after the last owner, wrapping mod 4.
    always_comb begin
        winner = last_owner_q;
        found  = 1'b0;
        cand   = last_owner_q;
        for (int k = 0; k < 4; k++) begin
            cand = last_owner_q + 2'(k) + 2'd1;
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Select the current owner's write data and control bits.
    always_comb begin
        wsel = '0;
        for (int k = 0; k < 4; k++) begin
            if (last_owner_q == 2'(k)) begin
                wsel = wdata[k*WIDTH +: WIDTH];
            end
        end
        owner_req = req[last_owner_q];
        owner_oe  = oe_req[last_owner_q];
    end

    // Next-state logic; last_owner doubles as the current owner while granted.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;
        pin_oe_d     = 1'b0;
        pin_dout_d   = '0;
        rdata_d      = rdata_q;
        rvalid_d     = 1'b0;
        timeout_d    = 1'b0;
        busy_d       = busy_q;
        case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d      = StGrant;
                    gnt_d        = 4'b0001 << winner;
                    last_owner_d = winner;
                    hold_cnt_d   = '0;
                    busy_d       = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            StGrant: begin
                hold_cnt_d = hold_cnt_q + 8'd1;
                if (!owner_req || hold_cnt_q == HoldLast) begin
                    // A release with req still high can only be the hold limit.
                    state_d   = StTurn;
                    gnt_d     = '0;
                    timeout_d = owner_req;
                end else begin
                    pin_oe_d   = owner_oe;
                    pin_dout_d = wsel;
                    if (!owner_oe) begin
                        rdata_d  = pin_din;
                        rvalid_d = 1'b1;
                    end
                end
            end
            StTurn: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops the pin driver without a clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            gnt_q        <= '0;
            last_owner_q <= 2'd3;
            hold_cnt_q   <= '0;
            pin_oe_q     <= 1'b0;
            pin_dout_q   <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            pin_oe_q     <= pin_oe_d;
            pin_dout_q   <= pin_dout_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
        end
    end

    assign gnt      = gnt_q;
    assign pin_oe   = pin_oe_q;
    assign pin_dout = pin_dout_q;
    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign timeout  = timeout_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_io_pin_arbiter.sv
// Bench for io_pin_arbiter: directed scenarios followed by random traffic,
// every cycle compared against an ownership-level reference model.
module tb_io_pin_arbiter;

    localparam int W    = 8;
    localparam int MAXH = 4;

    logic           clock = 1'b0;
    logic           reset_n;
    logic [3:0]     req;
    logic [3:0]     oe_req;
    logic [4*W-1:0] wdata;
    logic [W-1:0]   pin_din;
    logic [W-1:0]   pin_dout;
    logic           pin_oe;
    logic [3:0]     gnt;
    logic [W-1:0]   rdata;
    logic           rvalid;
    logic           timeout;
    logic           busy;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the bank, for how many cycles, and whether
    // the bank is in its turnaround cycle.
    int         m_owner;
    int         m_cycles;
    int         m_last;
    bit         m_turn;
    logic [W-1:0] e_pin_dout;
    logic         e_pin_oe;
    logic [W-1:0] e_rdata;
    logic         e_rvalid;
    logic         e_timeout;

    int order[$];
    int waited;
    int cnt;

    io_pin_arbiter #(
        .WIDTH    (W),
        .MAX_HOLD (MAXH)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req),
        .oe_req   (oe_req),
        .wdata    (wdata),
        .pin_din  (pin_din),
        .pin_dout (pin_dout),
        .pin_oe   (pin_oe),
        .gnt      (gnt),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .timeout  (timeout),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_cycles  = 0;
        m_last    = 3;
        m_turn    = 1'b0;
        e_pin_dout = '0;
        e_pin_oe  = 1'b0;
        e_rdata   = '0;
        e_rvalid  = 1'b0;
        e_timeout = 1'b0;
    endtask

    // Apply the ownership rules to the inputs seen at one rising edge.
    task automatic model_edge();
        e_pin_oe   = 1'b0;
        e_pin_dout = '0;
        e_rvalid   = 1'b0;
        e_timeout  = 1'b0;
        if (m_owner >= 0) begin
            if (!req[m_owner] || m_cycles == MAXH) begin
                e_timeout = req[m_owner];
                m_owner   = -1;
                m_turn    = 1'b1;
            end else begin
                m_cycles++;
                e_pin_oe   = oe_req[m_owner];
                e_pin_dout = wdata[m_owner*W +: W];
                if (!oe_req[m_owner]) begin
                    e_rdata  = pin_din;
                    e_rvalid = 1'b1;
                end
            end
        end else if (m_turn) begin
            m_turn = 1'b0;
        end else if (req != 4'b0000) begin
            for (int k = 1; k <= 4; k++) begin
                if (m_owner < 0 && req[(m_last + k) % 4]) begin
                    m_owner = (m_last + k) % 4;
                end
            end
            m_last   = m_owner;
            m_cycles = 1;
        end
    endtask

    task automatic check_all();
        logic [3:0] e_gnt;
        e_gnt = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("pin_oe", 32'(pin_oe), 32'(e_pin_oe));
        check("pin_dout", 32'(pin_dout), 32'(e_pin_dout));
        check("rdata", 32'(rdata), 32'(e_rdata));
        check("rvalid", 32'(rvalid), 32'(e_rvalid));
        check("timeout", 32'(timeout), 32'(e_timeout));
        check("busy", 32'(busy), 32'((m_owner >= 0) || m_turn));
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        check("oe_needs_gnt", 32'(!pin_oe || (gnt != 4'b0000)), 32'd1);
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_all();
    endtask

    task automatic wait_grant();
        waited = 0;
        while (gnt == 4'b0000 && waited < 10) begin
            tick();
            waited++;
        end
        check("grant_wait", 32'(gnt != 4'b0000), 32'd1);
    endtask

    initial begin
        req     = '0;
        oe_req  = '0;
        wdata   = '0;
        pin_din = '0;
        do_reset();

        // Single write from requester 0.
        req    = 4'b0001;
        oe_req = 4'b0001;
        wdata  = {24'h0, 8'hA5};
        tick();
        check("wr_gnt", 32'(gnt), 32'h1);
        tick();
        check("wr_dout", 32'(pin_dout), 32'hA5);
        req = 4'b0000;
        tick();
        check("wr_turn_oe", 32'(pin_oe), 32'h0);
        tick();

        // Round robin with every requester releasing after two cycles.
        do_reset();
        oe_req = 4'b1111;
        wdata  = 32'h44332211;
        for (int n = 0; n < 5; n++) begin
            req = 4'b1111;
            wait_grant();
            if (n > 0) check("rr_gap", 32'(waited), 32'd2);
            for (int b = 0; b < 4; b++) if (gnt[b]) order.push_back(b);
            tick();
            req = 4'b1111 & ~gnt;
            tick();
        end
        req = 4'b1111;
        check("rr_count", 32'(order.size()), 32'd5);
        for (int n = 0; n < order.size(); n++) check("rr_order", 32'(order[n]), 32'(n % 4));

        // Read by requester 2.
        do_reset();
        req     = 4'b0100;
        oe_req  = 4'b0000;
        pin_din = 8'h3C;
        tick();
        tick();
        check("rd_rdata", 32'(rdata), 32'h3C);
        check("rd_rvalid", 32'(rvalid), 32'h1);
        req = 4'b0000;
        tick();
        tick();

        // Timeout: requester 1 never lets go.
        do_reset();
        req    = 4'b0010;
        oe_req = 4'b0010;
        wait_grant();
        cnt = 0;
        while (gnt == 4'b0010 && cnt < 20) begin
            cnt++;
            tick();
        end
        check("to_cycles", 32'(cnt), 32'(MAXH));
        check("to_pulse", 32'(timeout), 32'h1);
        tick();
        tick();
        check("to_regrant", 32'(gnt), 32'h2);

        // Reset mid-grant while driving the pins.
        tick();
        check("rst_pre_oe", 32'(pin_oe), 32'h1);
        #1 reset_n = 1'b0;
        #1;
        check("rst_async_oe", 32'(pin_oe), 32'h0);
        check("rst_async_gnt", 32'(gnt), 32'h0);
        check("rst_async_busy", 32'(busy), 32'h0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        req = 4'b0100;
        tick();
        check("rst_regrant", 32'(gnt), 32'h4);

        // Release on the final allowed cycle is a normal release.
        do_reset();
        req = 4'b0010;
        wait_grant();
        repeat (MAXH - 1) tick();
        req = 4'b0000;
        tick();
        check("edge_turn_gnt", 32'(gnt), 32'h0);
        check("edge_no_timeout", 32'(timeout), 32'h0);
        tick();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            req     = 4'($urandom_range(0, 15));
            oe_req  = 4'($urandom_range(0, 15));
            wdata   = $urandom;
            pin_din = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 60) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_pin_arbiter.md
IO_PIN_ARBITER -- requirements
Module: io_pin_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of the shared SB_IO pin bank.
REQ-002 SHALL have parameter MAX_HOLD, default 16: maximum consecutive GRANT cycles per ownership; legal range 2..255.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have the following ports, clock and reset first:
 - clock     input   1          rising-edge clock
 - reset_n   input   1          async active-low reset
 - req       input   4          request per requester; held high while ownership is wanted
 - oe_req    input   4          requester i drives the pins (1) or samples them (0)
 - wdata     input   4*WIDTH    requester i data in bits [i*WIDTH +: WIDTH]
 - pin_din   input   WIDTH      from SB_IO D_IN_0
 - pin_dout  output  WIDTH      to SB_IO D_OUT_0
 - pin_oe    output  1          to SB_IO OUTPUT_ENABLE
 - gnt       output  4          one-hot current owner; all-zero when no owner
 - rdata     output  WIDTH      registered pin sample
 - rvalid    output  1          rdata valid strobe
 - timeout   output  1          forced-release strobe
 - busy      output  1          high in GRANT or TURN

Function
REQ-005 SHALL implement states IDLE, GRANT and TURN, all outputs registered.
REQ-006 IDLE: if any req is high at edge t, SHALL enter GRANT at t+1 with gnt one-hot on the winner; otherwise SHALL stay in IDLE.
REQ-007 Arbitration SHALL be round-robin: search starts at requester (last_owner+1) mod 4; last_owner updates on each grant.
REQ-008 In GRANT, each cycle SHALL register pin_oe <= oe_req[owner] and pin_dout <= wdata[owner] (one-cycle latency from inputs to pins).
REQ-009 In GRANT, when the owner's oe_req is 0 on a cycle, SHALL register rdata <= pin_din and pulse rvalid for one cycle on the following edge.
REQ-010 rvalid SHALL be 0 whenever the owner is driving, and in IDLE and TURN.
REQ-011 hold_cnt SHALL clear on entry to GRANT and increment every GRANT cycle.
REQ-012 GRANT->TURN SHALL occur when req[owner] is sampled low, or when hold_cnt reaches MAX_HOLD-1, so an owner holds at most MAX_HOLD cycles.
REQ-013 On a MAX_HOLD release with req[owner] still high, SHALL pulse timeout for one cycle, coincident with entry to TURN.
REQ-014 If req drops on the same cycle the MAX_HOLD limit is reached, SHALL treat it as a normal release with no timeout pulse.
REQ-015 TURN SHALL last exactly one cycle with gnt=0, pin_oe=0 and pin_dout=0, then go to IDLE (bus turnaround; no two owners are ever back-to-back).
REQ-016 Minimum owner-to-owner gap SHALL be: release edge, one TURN cycle, one IDLE cycle, then the next GRANT.
REQ-017 Changes to req of non-owners during GRANT or TURN SHALL NOT affect the current owner.
REQ-018 A timed-out requester SHALL be re-grantable only by normal rotation; if it is the sole requester it SHALL be granted again.
REQ-019 gnt SHALL never have more than one bit set, and pin_oe SHALL be 1 only when gnt is non-zero.

Reset
REQ-020 On reset_n low, SHALL asynchronously force state=IDLE, gnt=0, pin_oe=0, pin_dout=0, rdata=0, rvalid=0, timeout=0, busy=0, hold_cnt=0 and last_owner=3, so requester 0 has first priority.
REQ-021 Reset asserted mid-GRANT SHALL drop pin_oe immediately (no clock edge needed); after release, SHALL resume arbitration from IDLE.

Verification
REQ-022 Single write: req=0001, oe_req=0001, wdata[0]=8'hA5 -> gnt=0001 one cycle later, then pin_oe=1, pin_dout=8'hA5; drop req -> TURN (pin_oe=0), then IDLE.
REQ-023 Round-robin: req=1111 held with each owner releasing after 2 cycles -> grant order 0,1,2,3,0 with one TURN and one IDLE cycle between owners.
REQ-024 Read: owner 2 with oe_req[2]=0 and pin_din=8'h3C -> rvalid=1 and rdata=8'h3C on the following edge; pin_oe stays 0.
REQ-025 Timeout: MAX_HOLD=4, req[1] held high -> exactly 4 GRANT cycles, timeout pulses at TURN entry, requester 1 regranted after TURN+IDLE.
REQ-026 Reset mid-GRANT with pin_oe=1 -> pin_oe, gnt and busy go 0 asynchronously; after release, req=0100 -> gnt=0100.
REQ-027 Boundary: req[owner] drops on the MAX_HOLD-1 cycle -> TURN with timeout=0; random stimulus -> gnt always one-hot or zero.
